// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared FSM state encoding and command-byte constants for the
//            spi_reg master/slave pair.
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        CMD     = 3'd2,
        GAP     = 3'd3,
        DATA    = 3'd4,
        HOLD    = 3'd5,
        RECOVER = 3'd6
    } spi_state_t;

    localparam int REG_W_DFLT = 8;
    // Position of the read/write flag in the command byte, as decoded by spi_reg.
    localparam int CMD_RW_BIT = REG_W_DFLT - 1;

endpackage
`default_nettype wire

// File: rtl/spi_reg_master_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_master_if
// Purpose  : Register-access request bus between a requester and spi_reg_master.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_reg_master_if #(
    parameter int ADDR_W = 3,
    parameter int REG_W  = 8
);
    logic              start;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [REG_W-1:0]  wdata;
    logic              busy;
    logic              done;
    logic [REG_W-1:0]  rdata;

    modport master (output start, rw, addr, wdata, input busy, done, rdata);
    modport slave  (input start, rw, addr, wdata, output busy, done, rdata);
endinterface
`default_nettype wire

// File: rtl/spi_reg_master_half_period_counter.sv
`default_nettype none
// ============================================================================
// Module   : spi_half_period_counter
// Purpose  : Free-running CLK_DIV cycle counter; tick marks the last cycle of
//            each half-period, pre_tick the cycle before it.
// Revision : 1.0 - initial release
// ============================================================================
module spi_half_period_counter #(
    parameter int CLK_DIV = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic ena,
    input  wire logic load,
    output logic      tick,
    output logic      pre_tick
);
    localparam int                CNT_W  = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]  C_LOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // Reloads itself on every tick so consecutive phases chain without gaps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= C_LOAD;
        end else if (load) begin
            r_cnt <= C_LOAD;
        end else if (ena) begin
            r_cnt <= (r_cnt == '0) ? C_LOAD : r_cnt - 1'b1;
        end
    end

    assign tick     = ena && (r_cnt == '0);
    assign pre_tick = (r_cnt == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/spi_reg_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_master
// Purpose  : Mode-0 SPI master issuing two-byte (command, data) register
//            frames to the spi_reg slave; captures MISO for reads.
// Revision : 1.0 - initial release
// ============================================================================
module spi_reg_master
    import spi_pkg::*;
#(
    parameter int ADDR_W  = 3,
    parameter int REG_W   = REG_W_DFLT,
    parameter int CLK_DIV = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        ena,
    spi_reg_master_if.slave  bus,
    output logic             spi_clk,
    output logic             spi_cs_n,
    output logic             spi_mosi,
    input  wire logic        spi_miso
);
    localparam int               BIT_W      = $clog2(REG_W);
    localparam logic [BIT_W-1:0] C_LAST_BIT = BIT_W'(REG_W - 1);

    spi_state_t       r_state;
    logic [REG_W-1:0] r_cmd_sh;
    logic [REG_W-1:0] r_data_sh;
    logic [REG_W-1:0] r_rx;
    logic [REG_W-1:0] r_rdata;
    logic [BIT_W-1:0] r_bit;
    logic             r_half;
    logic             r_rw;
    logic             r_busy;
    logic             r_done;
    logic             r_sclk;
    logic             r_csn;
    logic             r_mosi;
    logic [REG_W-1:0] w_cmd;
    logic             w_tick;
    logic             w_pre_tick;

    always_comb begin
        w_cmd              = '0;
        w_cmd[REG_W-1]     = bus.rw;
        w_cmd[ADDR_W-1:0]  = bus.addr;
    end

    spi_half_period_counter #(
        .CLK_DIV (CLK_DIV)
    ) u_hp_cnt (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .load     (r_state == IDLE),
        .tick     (w_tick),
        .pre_tick (w_pre_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cmd_sh  <= '0;
            r_data_sh <= '0;
            r_rx      <= '0;
            r_rdata   <= '0;
            r_bit     <= '0;
            r_half    <= 1'b0;
            r_rw      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sclk    <= 1'b0;
            r_csn     <= 1'b1;
            r_mosi    <= 1'b0;
        end else if (ena) begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state   <= SETUP;
                        r_busy    <= 1'b1;
                        r_csn     <= 1'b0;
                        r_cmd_sh  <= w_cmd;
                        // Reads clock out zeros in the data byte.
                        r_data_sh <= bus.rw ? bus.wdata : '0;
                        r_rw      <= bus.rw;
                        r_mosi    <= w_cmd[REG_W-1];
                        r_bit     <= '0;
                        r_half    <= 1'b0;
                    end
                end
                SETUP: begin
                    if (w_tick) r_state <= CMD;
                end
                CMD, DATA: begin
                    if (w_tick) begin
                        if (!r_sclk) begin
                            r_sclk <= 1'b1;
                            r_rx   <= {r_rx[REG_W-2:0], spi_miso};
                        end else begin
                            r_sclk <= 1'b0;
                            r_bit  <= r_bit + 1'b1;
                            if (r_bit == C_LAST_BIT) begin
                                r_bit <= '0;
                                if (r_state == CMD) begin
                                    r_state <= GAP;
                                    r_mosi  <= r_data_sh[REG_W-1];
                                end else begin
                                    r_state <= HOLD;
                                    r_mosi  <= 1'b0;
                                end
                            end else if (r_state == CMD) begin
                                r_cmd_sh <= r_cmd_sh << 1;
                                r_mosi   <= r_cmd_sh[REG_W-2];
                            end else begin
                                r_data_sh <= r_data_sh << 1;
                                r_mosi    <= r_data_sh[REG_W-2];
                            end
                        end
                    end
                end
                GAP: begin
                    // Two half-periods: slave decodes the command and loads TX.
                    if (w_tick) begin
                        r_half <= ~r_half;
                        if (r_half) r_state <= DATA;
                    end
                end
                HOLD: begin
                    if (w_tick) begin
                        r_state <= RECOVER;
                        r_csn   <= 1'b1;
                    end
                end
                RECOVER: begin
                    if (w_pre_tick) begin
                        r_done <= 1'b1;
                        if (!r_rw) r_rdata <= r_rx;
                    end
                    if (w_tick) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.rdata = r_rdata;
    assign spi_clk   = r_sclk;
    assign spi_cs_n  = r_csn;
    assign spi_mosi  = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_reg_master
// Purpose  : Self-checking bench for spi_reg_master with a behavioural spi_reg
//            register-file slave on the SPI pins.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_reg_master;
    localparam int ADDR_W  = 3;
    localparam int REG_W   = 8;
    localparam int CLK_DIV = 4;

    logic clk = 1'b0;
    logic rst;
    logic ena;
    logic spi_clk, spi_cs_n, spi_mosi, spi_miso;

    spi_reg_master_if #(.ADDR_W(ADDR_W), .REG_W(REG_W)) bus ();

    spi_reg_master #(
        .ADDR_W  (ADDR_W),
        .REG_W   (REG_W),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .bus      (bus),
        .spi_clk  (spi_clk),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural spi_reg: command byte then data byte, mode 0.
    logic [7:0]  regs [8] = '{8'h00, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [15:0] m_sh     = '0;
    int          m_bits   = 0;
    logic [7:0]  m_tx     = '0;
    logic [7:0]  obs_cmd  = '0;
    logic [7:0]  obs_data = '0;
    int          dv_cnt   = 0;
    logic [7:0]  dv_data  = '0;

    assign spi_miso = m_tx[7];

    always @(posedge spi_clk or posedge spi_cs_n) begin
        if (spi_cs_n === 1'b1) begin
            if (m_bits == 16) begin
                obs_cmd  = m_sh[15:8];
                obs_data = m_sh[7:0];
                if (m_sh[15]) begin
                    regs[m_sh[10:8]] = m_sh[7:0];
                    dv_cnt++;
                    dv_data = m_sh[7:0];
                end
            end else begin
                obs_cmd  = 8'hEE;
                obs_data = 8'hEE;
            end
            m_bits = 0;
        end else begin
            m_sh = {m_sh[14:0], spi_mosi};
            m_bits++;
            if (m_bits == 8)     m_tx = m_sh[7] ? 8'h00 : regs[m_sh[2:0]];
            else if (m_bits > 8) m_tx = m_tx << 1;
        end
    end

    int   cs_cnt   = 0;
    logic prev_csn = 1'b1;
    always @(negedge clk) begin
        if (spi_cs_n === 1'b0) cs_cnt = prev_csn ? 1 : cs_cnt + 1;
        prev_csn = spi_cs_n;
    end

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        logic [7:0] rdata;
        int         cs;
        logic       wr;
        logic [7:0] wd;
    } exp_t;

    exp_t sb_q[$];
    int   done_cnt = 0;
    int   last_dv  = 0;

    always @(negedge clk) begin : sb_chk
        exp_t e;
        if (bus.done === 1'b1) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("cmd_byte", obs_cmd, e.cmd);
                check("mosi_data", obs_data, e.data);
                check("rdata", bus.rdata, e.rdata);
                check("cs_low_cycles", cs_cnt, e.cs);
                if (e.wr) begin
                    check("dv_count", dv_cnt, last_dv + 1);
                    check("dv_data", dv_data, e.wd);
                end else begin
                    check("dv_count", dv_cnt, last_dv);
                end
                last_dv = dv_cnt;
            end
        end
    end

    typedef struct {
        logic       rw;
        logic [2:0] addr;
        logic [7:0] wdata;
        bit         stall;
        bit         poke;
        bit         b2b;
        logic [7:0] cmd;
        logic [7:0] data;
        logic [7:0] rdata;
        int         cs;
        int         lat;
    } vec_t;

    task automatic run_txn(input vec_t v, input bit do_reset);
        int n;
        int waits;
        exp_t e;
        waits = 0;
        while (bus.busy !== 1'b0 && waits < 1000) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 1000) check("idle_timeout", 32'd1, 32'd0);
        if (v.b2b) check("b2b_accept_slot", waits, 1);
        if (!do_reset) begin
            e = '{v.cmd, v.data, v.rdata, v.cs, v.rw, v.wdata};
            sb_q.push_back(e);
        end
        bus.start = 1'b1;
        bus.rw    = v.rw;
        bus.addr  = v.addr;
        bus.wdata = v.wdata;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        check("accept_busy", bus.busy, 1);
        check("accept_csn", spi_cs_n, 0);
        while (bus.done !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
            if (v.stall && n == 100) ena = 1'b0;
            if (v.stall && n == 120) ena = 1'b1;
            if (v.poke && (n == 10 || n == 80)) begin
                bus.start = 1'b1;
                bus.rw    = 1'b0;
                bus.addr  = 3'd7;
            end else if (v.poke) begin
                bus.start = 1'b0;
            end
            if (do_reset && n == 50) begin
                rst = 1'b1;
                #1;
                check("rst_mid_csn", spi_cs_n, 1);
                check("rst_mid_sclk", spi_clk, 0);
                check("rst_mid_busy", bus.busy, 0);
                check("rst_mid_rdata", bus.rdata, 0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
        end
        check("done_latency", n, v.lat);
    endtask

    vec_t vecs[6];
    vec_t v_rst;
    vec_t v_fin;

    initial begin
        vecs[0] = '{1'b1, 3'd5, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h85, 8'hA5, 8'h00, 144, 148};
        vecs[1] = '{1'b0, 3'd3, 8'h00, 1'b0, 1'b0, 1'b1, 8'h03, 8'h00, 8'h3C, 144, 148};
        vecs[2] = '{1'b1, 3'd5, 8'hA5, 1'b1, 1'b0, 1'b1, 8'h85, 8'hA5, 8'h3C, 164, 168};
        vecs[3] = '{1'b1, 3'd2, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h82, 8'h5A, 8'h3C, 144, 148};
        vecs[4] = '{1'b0, 3'd2, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h02, 8'h00, 8'h5A, 144, 148};
        vecs[5] = '{1'b0, 3'd5, 8'h00, 1'b0, 1'b0, 1'b1, 8'h05, 8'h00, 8'hA5, 144, 148};
        v_rst   = '{1'b1, 3'd6, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0, 0};
        v_fin   = '{1'b1, 3'd7, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h87, 8'h3C, 8'h00, 144, 148};

        rst       = 1'b1;
        ena       = 1'b1;
        bus.start = 1'b0;
        bus.rw    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_rdata", bus.rdata, 0);
        check("reset_sclk", spi_clk, 0);
        check("reset_csn", spi_cs_n, 1);
        check("reset_mosi", spi_mosi, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) run_txn(vecs[i], 1'b0);

        // Abort mid-command, then confirm a clean frame afterwards.
        run_txn(v_rst, 1'b1);
        repeat (3) @(negedge clk);
        check("post_rst_csn", spi_cs_n, 1);
        run_txn(v_fin, 1'b0);

        repeat (10) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        check("done_count", done_cnt, 7);
        check("reg2_model", regs[2], 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
